// File: rtl/mem_bus_arbiter.sv
// Two-master (instruction fetch I, load/store D) to one-slave bus arbiter.
// D has priority, a streak counter bounds I starvation, and a watchdog turns a hung slave into err.
module mem_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int MAX_D_STREAK   = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        i_cyc_i,
  input  logic        i_stb_i,
  input  logic        i_we_i,
  input  logic [3:0]  i_sel_i,
  input  logic [31:0] i_addr_i,
  input  logic [31:0] i_data_i,
  output logic        i_ack_o,
  output logic        i_err_o,
  output logic [31:0] i_data_o,
  input  logic        d_cyc_i,
  input  logic        d_stb_i,
  input  logic        d_we_i,
  input  logic [3:0]  d_sel_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_data_i,
  output logic        d_ack_o,
  output logic        d_err_o,
  output logic [31:0] d_data_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_data_o,
  input  logic        s_ack_i,
  input  logic        s_err_i,
  input  logic [31:0] s_data_i,
  output logic        timeout_o
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

  localparam logic [15:0] WAIT_LAST  = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  STREAK_MAX = 8'(MAX_D_STREAK);

  state_t      state_reg;
  logic [7:0]  d_streak_reg;
  logic [15:0] wait_cnt_reg;

  logic i_req, d_req, gnt_i, gnt_d, gnt_cyc, slave_done, wd_fire, xfer_done, force_i;

  assign i_req      = i_cyc_i & i_stb_i;
  assign d_req      = d_cyc_i & d_stb_i;
  assign gnt_i      = (state_reg == GNT_I);
  assign gnt_d      = (state_reg == GNT_D);
  assign gnt_cyc    = (gnt_i & i_cyc_i) | (gnt_d & d_cyc_i);
  assign slave_done = s_ack_i | s_err_i;
  // A slave ack arriving on the last allowed cycle beats the watchdog.
  assign wd_fire    = (gnt_i | gnt_d) & (wait_cnt_reg == WAIT_LAST) & ~slave_done;
  assign xfer_done  = slave_done | wd_fire | ~gnt_cyc;
  assign force_i    = i_req & (d_streak_reg == STREAK_MAX);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg    <= IDLE;
      d_streak_reg <= 8'd0;
      wait_cnt_reg <= 16'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          wait_cnt_reg <= 16'd0;
          if (d_req && !force_i) begin
            state_reg <= GNT_D;
            if (i_req)
              d_streak_reg <= d_streak_reg + 8'd1;
          end else if (i_req) begin
            state_reg    <= GNT_I;
            d_streak_reg <= 8'd0;
          end
        end
        GNT_I, GNT_D: begin
          if (xfer_done) begin
            state_reg    <= IDLE;
            wait_cnt_reg <= 16'd0;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 16'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Outputs derive from the async-reset state, so reset zeroes them immediately.
  always_comb begin
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    s_we_o    = 1'b0;
    s_sel_o   = 4'd0;
    s_addr_o  = 32'd0;
    s_data_o  = 32'd0;
    i_ack_o   = 1'b0;
    i_err_o   = 1'b0;
    i_data_o  = 32'd0;
    d_ack_o   = 1'b0;
    d_err_o   = 1'b0;
    d_data_o  = 32'd0;
    timeout_o = wd_fire;
    if (gnt_i) begin
      if (!wd_fire) begin
        s_cyc_o  = i_cyc_i;
        s_stb_o  = i_stb_i;
        s_we_o   = i_we_i;
        s_sel_o  = i_sel_i;
        s_addr_o = i_addr_i;
        s_data_o = i_data_i;
      end
      i_ack_o  = s_ack_i;
      i_err_o  = s_err_i | wd_fire;
      i_data_o = s_ack_i ? s_data_i : 32'd0;
    end else if (gnt_d) begin
      if (!wd_fire) begin
        s_cyc_o  = d_cyc_i;
        s_stb_o  = d_stb_i;
        s_we_o   = d_we_i;
        s_sel_o  = d_sel_i;
        s_addr_o = d_addr_i;
        s_data_o = d_data_i;
      end
      d_ack_o  = s_ack_i;
      d_err_o  = s_err_i | wd_fire;
      d_data_o = s_ack_i ? s_data_i : 32'd0;
    end
  end

endmodule
